// File: rtl/systolic_array_ctrl_if.sv
// Handshake and data bundle between the systolic array controller and its
// environment (operand source, PE array, result consumer).
//   i_startValid/o_startReady : operand pair handshake, data on i_a/i_b
//   o_peClear/o_doProcess     : PE accumulator clear and process enable
//   o_row/o_col               : diagonally skewed row/column feeds, slot 0 enters the array
//   i_c                       : PE results from the array
//   o_result/o_resultValid/i_resultReady : product handshake
// Modport slave is the controller side, master is the environment side.
interface systolic_array_ctrl_if #(
  parameter int N = 4
);
  localparam int D = 2*N-1;

  logic                      i_startValid;
  logic                      o_startReady;
  logic [N-1:0][N-1:0][7:0]  i_a;
  logic [N-1:0][N-1:0][7:0]  i_b;
  logic                      o_peClear;
  logic                      o_doProcess;
  logic [N-1:0][D-1:0][7:0]  o_row;
  logic [N-1:0][D-1:0][7:0]  o_col;
  logic [N-1:0][N-1:0][31:0] i_c;
  logic [N-1:0][N-1:0][31:0] o_result;
  logic                      o_resultValid;
  logic                      i_resultReady;

  modport slave (
    input  i_startValid, i_a, i_b, i_c, i_resultReady,
    output o_startReady, o_peClear, o_doProcess, o_row, o_col, o_result, o_resultValid
  );

  modport master (
    output i_startValid, i_a, i_b, i_c, i_resultReady,
    input  o_startReady, o_peClear, o_doProcess, o_row, o_col, o_result, o_resultValid
  );
endinterface

// File: rtl/systolic_array_ctrl.sv
// Sequencer for an NxN output-stationary systolic array.
// Accepts an operand pair (A, B), clears the PEs for one cycle, streams the
// skewed row/column feeds while o_doProcess is high for 3N-2 cycles, captures
// the array result one cycle later and offers it on a valid/ready handshake.
// Ports:
//   i_clk  : clock
//   i_arst : asynchronous active-high reset, aborts any job in flight
//   bus    : systolic_array_ctrl_if slave modport (handshakes, feeds, results)
module systolic_array_ctrl #(
  parameter int N = 4
) (
  input  logic                 i_clk,
  input  logic                 i_arst,
  systolic_array_ctrl_if.slave bus
);
  localparam int D          = 2*N-1;
  localparam int RUN_CYCLES = 3*N-2;
  localparam int CW         = $clog2(3*N);

  typedef logic [N-1:0][D-1:0][7:0] feed_t;
  typedef logic [N-1:0][N-1:0][7:0] mat_t;
  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  state_t                    state;
  state_t                    state_next;
  logic [CW-1:0]             cycle_cnt;
  feed_t                     row_q;
  feed_t                     col_q;
  logic [N-1:0][N-1:0][31:0] result_q;
  logic                      start_ready;
  logic                      pe_clear;
  logic                      do_process;
  logic                      result_valid;
  logic                      accept;
  logic                      run_last;

  // Row i is delayed by i slots so A[i][k] lands in slot i+k.
  function automatic feed_t skew_rows(input mat_t m);
    skew_rows = '0;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++)
        skew_rows[i][i+k] = m[i][k];
  endfunction

  // Column j is delayed by j slots so B[k][j] lands in slot j+k.
  function automatic feed_t skew_cols(input mat_t m);
    skew_cols = '0;
    for (int j = 0; j < N; j++)
      for (int k = 0; k < N; k++)
        skew_cols[j][j+k] = m[k][j];
  endfunction

  assign accept   = start_ready && bus.i_startValid;
  // RUN holds one extra cycle past the enabled ones: that is the capture cycle.
  assign run_last = (cycle_cnt == CW'(RUN_CYCLES));

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = CLEAR;
      CLEAR:   state_next = RUN;
      RUN:     if (run_last) state_next = DONE;
      DONE:    if (bus.i_resultReady) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Ready is masked by reset so nothing is offered while the block is held.
  always_comb begin
    start_ready  = 1'b0;
    pe_clear     = 1'b0;
    do_process   = 1'b0;
    result_valid = 1'b0;
    case (state)
      IDLE:    start_ready  = !i_arst;
      CLEAR:   pe_clear     = 1'b1;
      RUN:     do_process   = !run_last;
      DONE:    result_valid = 1'b1;
      default: ;
    endcase
  end

  // Feeds, cycle counter and result capture. Feeds shift toward slot 0 at the
  // end of every RUN cycle, so RUN cycle t presents the original slot t.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      cycle_cnt <= '0;
      row_q     <= '0;
      col_q     <= '0;
      result_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          cycle_cnt <= '0;
          if (accept) begin
            row_q <= skew_rows(bus.i_a);
            col_q <= skew_cols(bus.i_b);
          end
        end
        CLEAR: cycle_cnt <= '0;
        RUN: begin
          for (int i = 0; i < N; i++) begin
            row_q[i] <= {8'h00, row_q[i][D-1:1]};
            col_q[i] <= {8'h00, col_q[i][D-1:1]};
          end
          if (run_last) result_q  <= bus.i_c;
          else          cycle_cnt <= cycle_cnt + 1'b1;
        end
        DONE: begin
          if (bus.i_resultReady) begin
            row_q <= '0;
            col_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_startReady  = start_ready;
  assign bus.o_peClear     = pe_clear;
  assign bus.o_doProcess   = do_process;
  assign bus.o_resultValid = result_valid;
  assign bus.o_row         = row_q;
  assign bus.o_col         = col_q;
  assign bus.o_result      = result_q;
endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Self-checking bench for systolic_array_ctrl. A behavioural NxN PE array
// consumes the controller's feeds and produces i_c; every returned product is
// compared against a plain matrix multiplication of the submitted operands.
module tb_systolic_array_ctrl;
  localparam int N = 4;
  localparam int D = 2*N-1;

  typedef logic [N-1:0][N-1:0][7:0] mat_t;

  logic clk = 1'b0;
  logic i_arst;
  int   n_compared   = 0;
  int   n_mismatched = 0;

  always #5 clk = ~clk;

  systolic_array_ctrl_if #(.N(N)) bus ();

  systolic_array_ctrl #(.N(N)) dut (
    .i_clk (clk),
    .i_arst(i_arst),
    .bus   (bus)
  );

  // Behavioural output-stationary PE array: operands march right/down one PE
  // per enabled cycle, each PE accumulates the products it sees.
  logic [7:0]  a_pipe [N][N];
  logic [7:0]  b_pipe [N][N];
  logic [31:0] acc    [N][N];
  logic [7:0]  a_in, b_in;

  always @(posedge clk) begin
    if (i_arst || bus.o_peClear) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          a_pipe[i][j] <= 8'd0;
          b_pipe[i][j] <= 8'd0;
          acc[i][j]    <= 32'd0;
        end
    end else if (bus.o_doProcess) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          if (j == 0) a_in = bus.o_row[i][0];
          else        a_in = a_pipe[i][j-1];
          if (i == 0) b_in = bus.o_col[j][0];
          else        b_in = b_pipe[i-1][j];
          acc[i][j]    <= acc[i][j] + 32'(a_in) * 32'(b_in);
          a_pipe[i][j] <= a_in;
          b_pipe[i][j] <= b_in;
        end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        bus.i_c[i][j] = acc[i][j];
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_row_slot(input mat_t a, input int i, input int t);
    if (t >= i && t - i < N) return a[i][t-i];
    return 8'd0;
  endfunction

  function automatic logic [7:0] exp_col_slot(input mat_t b, input int j, input int t);
    if (t >= j && t - j < N) return b[t-j][j];
    return 8'd0;
  endfunction

  task automatic checkFeeds(input string tag, input mat_t a, input mat_t b, input int shift);
    int bad_row = 0;
    int bad_col = 0;
    for (int i = 0; i < N; i++)
      for (int t = 0; t < D; t++) begin
        if (bus.o_row[i][t] !== ((t + shift < D) ? exp_row_slot(a, i, t + shift) : 8'd0)) bad_row++;
        if (bus.o_col[i][t] !== ((t + shift < D) ? exp_col_slot(b, i, t + shift) : 8'd0)) bad_col++;
      end
    checkOutput({tag, "_row_bad_slots"}, bad_row, 0);
    checkOutput({tag, "_col_bad_slots"}, bad_col, 0);
  endtask

  function automatic mat_t random_mat();
    mat_t m;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++)
        m[i][k] = 8'($urandom);
    return m;
  endfunction

  // Submits one job, watches the control sequence, checks the product and
  // the result handshake. hold == 0 means i_resultReady is high in advance.
  task automatic applyStimulus(input string name, input mat_t a, input mat_t b, input int hold);
    logic [31:0] exp_c [N][N];
    int wait_cnt = 0;
    int pe_cnt = 0, do_cnt = 0, ready_seen = 0;
    int first_clear = 0, first_do = 0, valid_cyc = 0;
    int bad;

    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        exp_c[i][j] = 0;
        for (int k = 0; k < N; k++)
          exp_c[i][j] += 32'(a[i][k]) * 32'(b[k][j]);
      end

    bus.i_resultReady = (hold == 0);
    bus.i_a = a;
    bus.i_b = b;
    bus.i_startValid = 1'b1;
    while (!bus.o_startReady && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (!bus.o_startReady) begin
      checkOutput({name, "_accept_timeout"}, 1, 0);
      bus.i_startValid = 1'b0;
      return;
    end
    @(negedge clk);
    bus.i_startValid = 1'b0;

    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (bus.o_peClear) begin
        pe_cnt++;
        if (first_clear == 0) first_clear = cyc;
      end
      if (bus.o_doProcess) begin
        do_cnt++;
        if (first_do == 0) first_do = cyc;
      end
      if (bus.o_startReady) ready_seen++;
      if (cyc == 1) checkFeeds({name, "_load"}, a, b, 0);
      if (cyc == 3) checkFeeds({name, "_shift1"}, a, b, 1);
      if (bus.o_resultValid) begin
        valid_cyc = cyc;
        break;
      end
      // Offer a different operand pair while the job runs; it must be ignored.
      if (cyc == 1) begin
        bus.i_a = random_mat();
        bus.i_b = random_mat();
        bus.i_startValid = 1'b1;
      end
      if (cyc == 10) bus.i_startValid = 1'b0;
      @(negedge clk);
    end
    bus.i_startValid = 1'b0;

    checkOutput({name, "_valid_cycle"}, valid_cyc, 3*N + 1);
    checkOutput({name, "_pe_clear_cycles"}, pe_cnt, 1);
    checkOutput({name, "_clear_position"}, first_clear, 1);
    checkOutput({name, "_do_process_cycles"}, do_cnt, 3*N - 2);
    checkOutput({name, "_first_run_cycle"}, first_do, 2);
    checkOutput({name, "_ready_while_busy"}, ready_seen, 0);
    if (valid_cyc == 0) return;

    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        checkOutput($sformatf("%s_c[%0d][%0d]", name, i, j), bus.o_result[i][j], exp_c[i][j]);

    for (int h = 0; h < hold; h++) begin
      bad = 0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          if (bus.o_result[i][j] !== exp_c[i][j]) bad++;
      checkOutput({name, "_held_result_bad"}, bad, 0);
      checkOutput({name, "_held_valid"}, bus.o_resultValid, 1);
      checkOutput({name, "_held_start_ready"}, bus.o_startReady, 0);
      @(negedge clk);
    end
    bus.i_resultReady = 1'b1;
    @(negedge clk);
    checkOutput({name, "_valid_after_consume"}, bus.o_resultValid, 0);
    checkOutput({name, "_ready_after_consume"}, bus.o_startReady, 1);
  endtask

  task automatic checkResetOutputs(input string name);
    checkOutput({name, "_start_ready"}, bus.o_startReady, 0);
    checkOutput({name, "_pe_clear"}, bus.o_peClear, 0);
    checkOutput({name, "_do_process"}, bus.o_doProcess, 0);
    checkOutput({name, "_result_valid"}, bus.o_resultValid, 0);
    checkOutput({name, "_row_nonzero"}, 32'(|bus.o_row), 0);
    checkOutput({name, "_col_nonzero"}, 32'(|bus.o_col), 0);
    checkOutput({name, "_result_nonzero"}, 32'(|bus.o_result), 0);
  endtask

  task automatic resetMidRun();
    int valid_seen = 0;
    bus.i_resultReady = 1'b1;
    bus.i_a = random_mat();
    bus.i_b = random_mat();
    bus.i_startValid = 1'b1;
    for (int w = 0; w < 20 && !bus.o_startReady; w++) @(negedge clk);
    @(negedge clk);
    bus.i_startValid = 1'b0;
    // Cycle 1 is CLEAR, so cycle 7 is RUN cycle 5.
    repeat (6) @(negedge clk);
    checkOutput("midrun_do_process_before_reset", bus.o_doProcess, 1);
    i_arst = 1'b1;
    #1;
    checkResetOutputs("midrun_reset");
    @(negedge clk);
    i_arst = 1'b0;
    #1;
    checkOutput("midrun_ready_after_release", bus.o_startReady, 1);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.o_resultValid) valid_seen++;
    end
    checkOutput("midrun_no_result", valid_seen, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    mat_t a, b;
    i_arst = 1'b1;
    bus.i_startValid = 1'b0;
    bus.i_resultReady = 1'b0;
    bus.i_a = '0;
    bus.i_b = '0;
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    i_arst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_reset", bus.o_startReady, 1);

    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        a[i][k] = (i == k) ? 8'd1 : 8'd0;
        b[i][k] = 8'(4*i + k + 1);
      end
    applyStimulus("identity", a, b, 0);

    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        a[i][k] = 8'd255;
        b[i][k] = 8'd255;
      end
    applyStimulus("max", a, b, 0);

    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++)
        a[i][k] = 8'(16*i + k);
    applyStimulus("skew", a, random_mat(), 2);

    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        a[i][k] = 8'd1;
        b[i][k] = 8'd1;
      end
    applyStimulus("b2b_ones", a, b, 0);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        a[i][k] = (i == k) ? 8'd1 : 8'd0;
        b[i][k] = (i == k) ? 8'd1 : 8'd0;
      end
    applyStimulus("b2b_identity", a, b, 0);

    applyStimulus("backpressure", random_mat(), random_mat(), 20);

    resetMidRun();

    for (int r = 0; r < 6; r++)
      applyStimulus($sformatf("random%0d", r), random_mat(), random_mat(),
                    ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule

// File: doc/systolic_array_ctrl.md
Name: systolic_array_ctrl

Overview:
- Sequencer in front of the NxN systolic array of PEs.
- Accepts a pair of NxN 8-bit operand matrices A and B through a valid/ready handshake, clears the PE accumulators, and builds the diagonally skewed row and column feed streams.
- Drives the array's process enable for exactly the required number of cycles, captures the NxN 32-bit product C = A x B, and returns it through a second valid/ready handshake.

Parameters:
- N, 4, array dimension. Matrices are NxN; the feed depth per row/column is D = 2N-1.

Ports:
- i_clk, input, 1, clock.
- i_arst, input, 1, asynchronous active-high reset.
- i_startValid, input, 1, operand pair on i_a/i_b is valid.
- o_startReady, output, 1, controller can accept an operand pair.
- i_a, input, [N-1:0][N-1:0][7:0], matrix A, indexed [row][k].
- i_b, input, [N-1:0][N-1:0][7:0], matrix B, indexed [k][col].
- o_peClear, output, 1, one-cycle synchronous clear of all PE accumulators and PE pipeline registers.
- o_doProcess, output, 1, array process enable.
- o_row, output, [N-1:0][D-1:0][7:0], skewed row feed; slot [i][0] enters row i.
- o_col, output, [N-1:0][D-1:0][7:0], skewed column feed; slot [j][0] enters column j.
- i_c, input, [N-1:0][N-1:0][31:0], PE results from the array.
- o_result, output, [N-1:0][N-1:0][31:0], captured product.
- o_resultValid, output, 1, o_result is valid.
- i_resultReady, input, 1, consumer accepts o_result.

Behaviour:
- Reset (async, i_arst=1): state IDLE, all counters 0, o_row/o_col/o_result all zero, o_doProcess=0, o_peClear=0, o_resultValid=0, o_startReady=0 during reset.
- Reset asserted mid-operation aborts the job; no partial result is ever presented.
- FSM states: IDLE -> CLEAR -> RUN -> DONE -> IDLE.
- IDLE:
  - o_startReady=1.
  - On i_startValid & o_startReady: load the skewed feeds and go to CLEAR.
  - Row feed load: o_row[i][t] = A[i][t-i] if 0 <= t-i < N, else 0.
  - Column feed load: o_col[j][t] = B[t-j][j] if 0 <= t-j < N, else 0.
- CLEAR:
  - o_peClear=1 for exactly one cycle; o_doProcess=0; feeds held.
  - Go to RUN with cycle counter = 0.
- RUN:
  - o_doProcess=1 for exactly 3N-2 consecutive cycles (10 for N=4).
  - Each RUN cycle after the first, every feed shifts one slot toward index 0 (slot[t] <= slot[t+1]); slot D-1 fills with 0.
  - After the 3N-2 RUN cycles, o_doProcess deasserts.
- Capture:
  - On the cycle after the last RUN cycle, o_result <= i_c and the FSM goes to DONE. This one-cycle margin covers the PE output register.
- DONE:
  - o_resultValid=1; o_result is held stable.
  - On i_resultReady=1: go to IDLE, drop o_resultValid, zero the feeds.
  - o_startReady=0 throughout DONE; no overlap of jobs.
- Handshakes and timing:
  - o_startReady=0 in CLEAR, RUN and DONE; i_startValid is ignored there.
  - i_a/i_b are sampled only at the accept edge.
  - Latency from accept to o_resultValid: 1 (CLEAR) + 3N-2 (RUN) + 1 (capture) = 3N cycles, i.e. 12 for N=4.
  - i_resultReady held high in advance: result is consumed on the first DONE cycle, and the next start can be accepted on the following cycle.
- Arithmetic: operands are unsigned 8-bit. Max element of C is N*255*255, which fits in 32 bits, so no saturation is needed.
- Cycle counter width is $clog2(3N); it wraps only through the reset/IDLE reload, never free-running.

Test Plan:
- Identity: A=I, B[k][j]=4k+j+1 -> after 12 cycles o_resultValid=1 and o_result==B.
- Max values: all A=255, all B=255 -> every o_result element = 260100; o_doProcess high for exactly 10 cycles; o_peClear high for exactly 1 cycle, preceding RUN.
- Feed skew: A[i][k]=16i+k -> at accept+1, o_row[1] slots 0..3 = {0,16,17,18}; after 1 RUN shift, o_row[0][0]=1.
- Back-to-back jobs with i_resultReady=1: first job all A=1/B=1 (C=4), second job identity/identity (C=I) -> second result exact, confirming the clear; i_startValid during RUN is not accepted.
- Backpressure: hold i_resultReady=0 for 20 cycles -> o_result stable, o_resultValid stays 1, o_startReady=0; release -> IDLE next cycle.
- Reset mid-RUN (cycle 5): all outputs zero immediately; after release o_startReady=1 and no o_resultValid appears.
